// File: rtl/fifo_access_ctrl_pkg.sv
// Shared types and constants for the FIFO access controller.
package fifo_access_ctrl_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        CLEAR     = 3'd0,
        SETTLE    = 3'd1,
        IDLE      = 3'd2,
        BUSY_PUSH = 3'd3,
        BUSY_POP  = 3'd4
    } state_t;

    // Last-grant encoding used by the round-robin arbiter.
    localparam logic GRANT_PUSH = 1'b0;
    localparam logic GRANT_POP  = 1'b1;

    // Width of the optional stall counters.
    localparam int STATS_W = 16;

    // Larger of two integers, used to size the phase counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_access_rr_arbiter.sv
// Two-way round-robin arbiter between the push and pop requesters.
// On a tie, it grants the requester that did not win last time.
module fifo_access_rr_arbiter
    import fifo_access_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic advance,
    input  logic req_push,
    input  logic req_pop,
    output logic grant_push,
    output logic grant_pop
);

    logic last_grant;

    // Pick a winner only when the controller is ready to issue a command.
    always_comb begin
        grant_push = 1'b0;
        grant_pop  = 1'b0;
        if (advance) begin
            if (req_push && req_pop) begin
                if (last_grant == GRANT_POP) begin
                    grant_push = 1'b1;
                end else begin
                    grant_pop = 1'b1;
                end
            end else begin
                grant_push = req_push;
                grant_pop  = req_pop;
            end
        end
    end

    // Remember the latest winner; reset favours push on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_POP;
        end else if (grant_push) begin
            last_grant <= GRANT_PUSH;
        end else if (grant_pop) begin
            last_grant <= GRANT_POP;
        end
    end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Sequencer/arbiter in front of the command-driven RS232 FIFO.
// Shares the FIFO between one writer and one reader, spaces push/pop strobes
// by CMD_GAP cycles, tracks occupancy, captures popped data after the FIFO
// read latency and runs the clear/settle sequence after reset or flush.
// Optional build macro: FIFO_ACCESS_CTRL_STATS_EN adds saturating stall counters.
module fifo_access_ctrl
    import fifo_access_ctrl_pkg::*;
#(
    parameter int FIFO_SIZE    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int CMD_GAP      = 3,
    parameter int RD_LATENCY   = 2,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           wr_valid,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           wr_ready,
    input  logic                           rd_req,
    output logic                           rd_valid,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           fifo_push,
    output logic                           fifo_pop,
    output logic                           fifo_clear,
    output logic [DATA_WIDTH-1:0]          fifo_in_data,
    input  logic [DATA_WIDTH-1:0]          fifo_out_data,
    output logic [$clog2(FIFO_SIZE+1)-1:0] level,
    output logic                           full,
    output logic                           empty,
    output logic                           busy
`ifdef FIFO_ACCESS_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0]             wr_stall_cnt,
    output logic [STATS_W-1:0]             rd_stall_cnt
`endif
);

    localparam int LVL_W = $clog2(FIFO_SIZE + 1);
    localparam int CNT_W = $clog2(max_int(CLEAR_CYCLES, CMD_GAP) + 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              flush_pending;
    logic              flush_any;
    logic              arb_advance;
    logic              wr_eligible;
    logic              rd_eligible;
    logic              grant_push;
    logic              grant_pop;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic              rd_capture;

    assign full       = (level == LVL_W'(FIFO_SIZE));
    assign empty      = (level == '0);
    assign busy       = (state != IDLE);
    assign fifo_clear = (state == CLEAR);

    assign flush_any   = flush | flush_pending;
    assign arb_advance = (state == IDLE) && !flush_any;
    assign wr_eligible = wr_valid && !full;
    assign rd_eligible = rd_req && !empty;
    assign rd_capture  = rd_pipe[RD_LATENCY-1];

    fifo_access_rr_arbiter u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (arb_advance),
        .req_push   (wr_eligible),
        .req_pop    (rd_eligible),
        .grant_push (grant_push),
        .grant_pop  (grant_pop)
    );

    // State and phase counter register; reset starts a clear sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic and the one-cycle strobes issued on IDLE grants.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        wr_ready   = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        case (state)
            CLEAR: begin
                if (cnt == CNT_W'(CLEAR_CYCLES - 1)) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end
            end
            SETTLE, BUSY_PUSH, BUSY_POP: begin
                if (cnt == CNT_W'(CMD_GAP - 2)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            IDLE: begin
                cnt_next = '0;
                if (flush_any) begin
                    state_next = CLEAR;
                end else if (grant_push) begin
                    wr_ready   = 1'b1;
                    fifo_push  = 1'b1;
                    state_next = BUSY_PUSH;
                end else if (grant_pop) begin
                    fifo_pop   = 1'b1;
                    state_next = BUSY_POP;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // Occupancy tracking; clearing the FIFO forces the count back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (state == CLEAR) begin
            level <= '0;
        end else if (fifo_push) begin
            level <= level + LVL_W'(1);
        end else if (fifo_pop) begin
            level <= level - LVL_W'(1);
        end
    end

    // Register the write word on each accepted write and hold it for the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_in_data <= '0;
        end else if (fifo_push) begin
            fifo_in_data <= wr_data;
        end
    end

    // A flush that arrives outside IDLE waits here until the next IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pending <= 1'b0;
        end else if (state == IDLE) begin
            flush_pending <= 1'b0;
        end else if (flush) begin
            flush_pending <= 1'b1;
        end
    end

    // Track each pop through the FIFO read latency, then capture and flag the word.
    // This pipeline is deliberately not cleared by flush so in-flight reads complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_pipe  <= (rd_pipe << 1) | RD_LATENCY'(fifo_pop);
            rd_valid <= rd_capture;
            if (rd_capture) begin
                rd_data <= fifo_out_data;
            end
        end
    end

`ifdef FIFO_ACCESS_CTRL_STATS_EN
    logic wr_stall;
    logic rd_stall;

    assign wr_stall = wr_valid && !wr_ready;
    assign rd_stall = rd_req && !fifo_pop && (rd_pipe == '0);

    // Saturating stall counters, cleared by reset or a flush request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_stall_cnt <= '0;
            rd_stall_cnt <= '0;
        end else if (flush) begin
            wr_stall_cnt <= '0;
            rd_stall_cnt <= '0;
        end else begin
            if (wr_stall && (wr_stall_cnt != '1)) begin
                wr_stall_cnt <= wr_stall_cnt + STATS_W'(1);
            end
            if (rd_stall && (rd_stall_cnt != '1)) begin
                rd_stall_cnt <= rd_stall_cnt + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Self-checking bench for fifo_access_ctrl with a behavioural FIFO model
// (two-cycle read latency) and scoreboards for written and read words.
module tb_fifo_access_ctrl;

    localparam int DW     = 32;
    localparam int LW     = 4;
    localparam int GAP    = 3;
    localparam int RD_LAT = 2;
    localparam int TMO    = 40;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_clear;
    logic [DW-1:0] fifo_in_data;
    logic [DW-1:0] fifo_out_data;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          busy;
`ifdef FIFO_ACCESS_CTRL_STATS_EN
    logic [15:0]   wr_stall_cnt;
    logic [15:0]   rd_stall_cnt;
`endif

    fifo_access_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_req        (rd_req),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .fifo_push     (fifo_push),
        .fifo_pop      (fifo_pop),
        .fifo_clear    (fifo_clear),
        .fifo_in_data  (fifo_in_data),
        .fifo_out_data (fifo_out_data),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .busy          (busy)
`ifdef FIFO_ACCESS_CTRL_STATS_EN
        ,
        .wr_stall_cnt  (wr_stall_cnt),
        .rd_stall_cnt  (rd_stall_cnt)
`endif
    );

    // Free-running clock and cycle index.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] wr_exp_q[$];
    logic [DW-1:0] rd_exp_q[$];
    int            pop_cyc_q[$];

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reportFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Behavioural FIFO: data popped at cycle T is presented only during T+2.
    logic          pop_d1;
    logic [DW-1:0] data_d1;
    logic [DW-1:0] model_q[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            pop_d1        <= 1'b0;
            data_d1       <= '0;
            fifo_out_data <= 32'hDEADBEEF;
        end else begin
            pop_d1        <= fifo_pop;
            fifo_out_data <= pop_d1 ? data_d1 : 32'hDEADBEEF;
            if (fifo_clear) begin
                model_q.delete();
            end else if (fifo_push) begin
                model_q.push_back(wr_data);
            end else if (fifo_pop) begin
                if (model_q.size() > 0) data_d1 <= model_q.pop_front();
                else                    data_d1 <= 32'hBAD0BAD0;
            end
        end
    end

    // Scoreboard monitor: strobe spacing, registered write data, read data and latency.
    logic          in_pending = 1'b0;
    logic [DW-1:0] in_exp     = '0;
    int            last_strobe = -100;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            in_pending = 1'b0;
        end else begin
            if (in_pending) begin
                checkOutput("fifo_in_data", fifo_in_data, in_exp);
                in_pending = 1'b0;
            end
            if (fifo_push || fifo_pop) begin
                checkOutput("strobe_gap", DW'(cyc - last_strobe >= GAP), 1);
                last_strobe = cyc;
            end
            if (fifo_push) begin
                if (wr_exp_q.size() > 0) begin
                    in_exp     = wr_exp_q.pop_front();
                    in_pending = 1'b1;
                end else begin
                    reportFail("unexpected_push");
                end
            end
            if (fifo_pop) pop_cyc_q.push_back(cyc);
            if (rd_valid) begin
                if (rd_exp_q.size() > 0) checkOutput("rd_data", rd_data, rd_exp_q.pop_front());
                else                     reportFail("unexpected_rd_valid");
                if (pop_cyc_q.size() > 0) checkOutput("rd_latency", DW'(cyc - pop_cyc_q.pop_front()), RD_LAT + 1);
                else                      reportFail("rd_valid_without_pop");
            end
        end
    end

    typedef struct {
        logic          rst_n;
        logic          wr_valid;
        logic [DW-1:0] wr_data;
        logic          exp_push;
        logic          exp_clear;
        logic          exp_busy;
        logic [LW-1:0] exp_level;
    } vec_t;

    vec_t vec_q[$];

    task automatic addVec(input logic r, input logic wv, input logic [DW-1:0] wd,
                          input logic ep, input logic ec, input logic eb, input logic [LW-1:0] el);
        vec_t v;
        v.rst_n = r; v.wr_valid = wv; v.wr_data = wd;
        v.exp_push = ep; v.exp_clear = ec; v.exp_busy = eb; v.exp_level = el;
        vec_q.push_back(v);
    endtask

    // Drive one table row on the falling edge and settle before checking.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n    = v.rst_n;
        wr_valid = v.wr_valid;
        wr_data  = v.wr_data;
        if (v.exp_push) wr_exp_q.push_back(v.wr_data);
        #1;
    endtask

    function automatic logic condMet(input int sel);
        case (sel)
            0:       return fifo_push;
            1:       return fifo_pop;
            2:       return rd_valid;
            3:       return fifo_push | fifo_pop;
            default: return !busy;
        endcase
    endfunction

    // Caller is at the sampling point of a cycle; returns at the sampling point where sel holds.
    task automatic waitFor(input int sel, input string name);
        int t = 0;
        while (!condMet(sel) && t < TMO) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!condMet(sel)) reportFail(name);
    endtask

    task automatic writeWord(input logic [DW-1:0] d, input logic hold);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_exp_q.push_back(d);
        #1;
        waitFor(0, "push_timeout");
        if (!hold) begin
            @(negedge clk);
            wr_valid = 1'b0;
            #1;
        end
    endtask

    task automatic readWord(input logic [DW-1:0] d);
        @(negedge clk);
        rd_req = 1'b1;
        rd_exp_q.push_back(d);
        #1;
        waitFor(2, "rd_valid_timeout");
        rd_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic          exp_is_push;
        logic          got_push;
        logic [LW-1:0] exp_lvl;
        logic [DW-1:0] next_wr;
`ifdef FIFO_ACCESS_CTRL_STATS_EN
        logic [15:0]   prev_stall;
`endif
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0;

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_clear", fifo_clear, 1);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_in_data", fifo_in_data, 0);

        // Release, clear/settle timing, then three words with wr_valid held.
        addVec(0, 0, 32'h00, 0, 1, 1, 0);
        addVec(1, 0, 32'h00, 0, 1, 1, 0);
        addVec(1, 0, 32'h00, 0, 1, 1, 0);
        addVec(1, 0, 32'h00, 0, 0, 1, 0);
        addVec(1, 0, 32'h00, 0, 0, 1, 0);
        addVec(1, 1, 32'h11, 1, 0, 0, 0);
        addVec(1, 1, 32'h22, 0, 0, 1, 1);
        addVec(1, 1, 32'h22, 0, 0, 1, 1);
        addVec(1, 1, 32'h22, 1, 0, 0, 1);
        addVec(1, 1, 32'h33, 0, 0, 1, 2);
        addVec(1, 1, 32'h33, 0, 0, 1, 2);
        addVec(1, 1, 32'h33, 1, 0, 0, 2);
        addVec(1, 0, 32'h00, 0, 0, 1, 3);
        addVec(1, 0, 32'h00, 0, 0, 1, 3);
        addVec(1, 0, 32'h00, 0, 0, 0, 3);
        foreach (vec_q[i]) begin
            applyStimulus(vec_q[i]);
            checkOutput($sformatf("tbl%0d_push", i), fifo_push, vec_q[i].exp_push);
            checkOutput($sformatf("tbl%0d_wr_ready", i), wr_ready, vec_q[i].exp_push);
            checkOutput($sformatf("tbl%0d_pop", i), fifo_pop, 0);
            checkOutput($sformatf("tbl%0d_clear", i), fifo_clear, vec_q[i].exp_clear);
            checkOutput($sformatf("tbl%0d_busy", i), busy, vec_q[i].exp_busy);
            checkOutput($sformatf("tbl%0d_level", i), level, vec_q[i].exp_level);
        end

        // Fill to FIFO_SIZE and keep wr_valid high: writer must stall.
        for (int k = 4; k <= 8; k++) writeWord(DW'(k * 32'h11), 1'b1);
`ifdef FIFO_ACCESS_CTRL_STATS_EN
        prev_stall = wr_stall_cnt;
`endif
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            checkOutput("full_wr_ready", wr_ready, 0);
            checkOutput("full_push", fifo_push, 0);
            checkOutput("full_flag", full, 1);
`ifdef FIFO_ACCESS_CTRL_STATS_EN
            checkOutput("wr_stall_inc", wr_stall_cnt, prev_stall + 16'd1);
            prev_stall = wr_stall_cnt;
`endif
        end
        checkOutput("full_level", level, 8);
        wr_valid = 1'b0;

        // Flush from IDLE empties the controller.
        waitFor(4, "idle_before_flush");
        @(negedge clk); flush = 1'b1; #1;
        checkOutput("flush_idle_no_clear_yet", fifo_clear, 0);
        @(negedge clk); flush = 1'b0; #1;
        checkOutput("flush_idle_clear", fifo_clear, 1);
        @(negedge clk); #1;
        waitFor(4, "idle_after_flush");
        checkOutput("flush_level", level, 0);
        checkOutput("flush_empty", empty, 1);
        checkOutput("flush_full", full, 0);

        // Read request while empty stays pending until a word arrives.
        @(negedge clk);
        rd_req = 1'b1;
        rd_exp_q.push_back(32'hA5A5A5A5);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            checkOutput("empty_no_pop", fifo_pop, 0);
        end
        writeWord(32'hA5A5A5A5, 1'b0);
        waitFor(2, "pending_rd_timeout");
        rd_req = 1'b0;
        checkOutput("after_read_level", level, 0);

        // Build level 4 with a pop last, then hold both requests.
        for (int k = 1; k <= 5; k++) writeWord(DW'(k), 1'b0);
        readWord(32'h1);
        checkOutput("pre_alt_level", level, 4);
        @(negedge clk);
        next_wr  = 32'h6;
        wr_valid = 1'b1;
        wr_data  = next_wr;
        wr_exp_q.push_back(next_wr);
        rd_req   = 1'b1;
        rd_exp_q.push_back(32'h2);
        rd_exp_q.push_back(32'h3);
        #1;
        exp_is_push = 1'b1;
        exp_lvl     = 4;
        for (int g = 0; g < 4; g++) begin
            waitFor(3, "alt_grant_timeout");
            got_push = fifo_push;
            checkOutput($sformatf("alt_grant%0d_is_push", g), got_push, exp_is_push);
            exp_lvl = got_push ? exp_lvl + 1 : exp_lvl - 1;
            @(negedge clk);
            if (got_push) begin
                next_wr = next_wr + 1;
                wr_data = next_wr;
                if (g < 2) wr_exp_q.push_back(next_wr);
            end
            if (g == 3) begin
                rd_req   = 1'b0;
                wr_valid = 1'b0;
            end
            #1;
            checkOutput($sformatf("alt_level%0d", g), level, exp_lvl);
            exp_is_push = !exp_is_push;
        end
        for (int t = 0; t < TMO && rd_exp_q.size() > 0; t++) begin
            @(negedge clk);
            #3;
        end
        checkOutput("alt_reads_drained", DW'(rd_exp_q.size()), 0);

        // Flush during BUSY_POP: the in-flight read still delivers.
        @(negedge clk);
        rd_req = 1'b1;
        rd_exp_q.push_back(32'h4);
        #1;
        waitFor(1, "flushpop_timeout");
        @(negedge clk); flush = 1'b1; #1;
        checkOutput("flushpop_busy", busy, 1);
        @(negedge clk); flush = 1'b0; #1;
        waitFor(2, "flushpop_rd_valid_timeout");
        rd_req = 1'b0;
        @(negedge clk); #1;
        checkOutput("flushpop_clear0", fifo_clear, 1);
        @(negedge clk); #1;
        checkOutput("flushpop_clear1", fifo_clear, 1);
        checkOutput("flushpop_level", level, 0);
        waitFor(4, "flushpop_idle");
        checkOutput("flushpop_empty", empty, 1);

        // Reset asserted in the middle of BUSY_PUSH.
        writeWord(32'hCAFEF00D, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_clear", fifo_clear, 1);
        checkOutput("midrst_busy", busy, 1);
        checkOutput("midrst_level", level, 0);
        checkOutput("midrst_in_data", fifo_in_data, 0);
        checkOutput("midrst_rd_data", rd_data, 0);
        checkOutput("midrst_rd_valid", rd_valid, 0);
        checkOutput("midrst_push", fifo_push, 0);
        checkOutput("midrst_pop", fifo_pop, 0);
        checkOutput("midrst_wr_ready", wr_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        waitFor(4, "midrst_idle");
        checkOutput("midrst_final_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
